// File: rtl/fifo_wr_if.sv
// Write-side FIFO bus: FIFO status flags in, write strobe/data and burst status out.
interface fifo_wr_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 9
);
  logic              almost_empty;
  logic              almost_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              wr_busy;
  logic              burst_done;
  logic [CNT_W-1:0]  burst_len;

  // Controller side
  modport master (
    input  almost_empty,
    input  almost_full,
    output fifo_wr_en,
    output fifo_wr_data,
    output wr_busy,
    output burst_done,
    output burst_len
  );

  // FIFO / observer side
  modport slave (
    output almost_empty,
    output almost_full,
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  wr_busy,
    input  burst_done,
    input  burst_len
  );
endinterface

// File: rtl/fifo_wr.sv
// FIFO write controller: on almost-empty, settles for DLY_MAX+1 cycles, then
// writes an incrementing burst until almost-full and reports its length.
module fifo_wr #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 9,
  parameter int unsigned DLY_MAX   = 10,
  parameter int unsigned START_VAL = 0
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  fifo_wr_if.master bus
);

  localparam int unsigned DLY_W = (DLY_MAX < 1) ? 1 : $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0]  DLY_TC  = DLY_W'(DLY_MAX);
  localparam logic [DATA_W-1:0] START_D = DATA_W'(START_VAL);
  localparam logic [CNT_W-1:0]  CNT_SAT = '1;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    WAIT_DLY = 4'b0010,
    WR_FIFO  = 4'b0100,
    WR_DONE  = 4'b1000
  } state_t;

  state_t            state_q;
  logic              ae_d0_q;
  logic              ae_d1_q;
  logic [DLY_W-1:0]  dly_cnt_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  len_q;

  // Two-flop synchroniser for the read-domain almost-empty flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ae_d0_q <= 1'b0;
      ae_d1_q <= 1'b0;
    end else begin
      ae_d0_q <= bus.almost_empty;
      ae_d1_q <= ae_d0_q;
    end
  end

  // Burst state machine with registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      dly_cnt_q <= '0;
      wcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= START_D;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ae_d1_q) begin
            state_q   <= WAIT_DLY;
            busy_q    <= 1'b1;
            dly_cnt_q <= '0;
            wcnt_q    <= '0;
            wr_data_q <= START_D;
          end
        end
        WAIT_DLY: begin
          if (dly_cnt_q == DLY_TC) begin
            state_q   <= WR_FIFO;
            wr_en_q   <= 1'b1;
            dly_cnt_q <= '0;
          end else begin
            dly_cnt_q <= dly_cnt_q + 1'b1;
          end
        end
        WR_FIFO: begin
          // The write presented this cycle is accepted even when almost_full is seen
          if (wr_en_q && (wcnt_q != CNT_SAT)) begin
            wcnt_q <= wcnt_q + 1'b1;
          end
          if (bus.almost_full) begin
            state_q <= WR_DONE;
            wr_en_q <= 1'b0;
          end else begin
            wr_en_q   <= 1'b1;
            wr_data_q <= wr_data_q + 1'b1;
          end
        end
        WR_DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          len_q   <= wcnt_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.wr_busy      = busy_q;
  assign bus.burst_done   = done_q;
  assign bus.burst_len    = len_q;

endmodule

// File: tb/tb_fifo_wr.sv
// Bench for fifo_wr: directed scenarios plus random-length bursts, checked
// against a word-level FIFO model (expected data i mod 256, length k+1).
module tb_fifo_wr;

  logic sys_clk;
  logic sys_rst_n;
  int   vectors;
  int   miscompares;

  fifo_wr_if #(.DATA_W(8), .CNT_W(9)) bus ();

  fifo_wr #(
    .DATA_W   (8),
    .CNT_W    (9),
    .DLY_MAX  (10),
    .START_VAL(0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
    chk({tag, "_data"},  32'(bus.fifo_wr_data), 32'd0);
    chk({tag, "_busy"},  32'(bus.wr_busy), 32'd0);
    chk({tag, "_done"},  32'(bus.burst_done), 32'd0);
    chk({tag, "_len"},   32'(bus.burst_len), 32'd0);
  endtask

  // One burst. The FIFO model raises almost_full once k words are stored,
  // so k+1 words are accepted in total. Latencies count falling edges from
  // the call (the first falling edge follows the first rising edge).
  task automatic do_burst(input int k, input int lat_exp, input int busy_exp,
                          input bit drop_ae, input string tag);
    int n = 0;
    int first_busy = 0;
    int wc = 0;
    do begin
      @(negedge sys_clk);
      n++;
      if (n == 1) chk({tag, "_done_low"}, 32'(bus.burst_done), 32'd0);
      if (bus.wr_busy && first_busy == 0) first_busy = n;
      if (drop_ae && n == 5) bus.almost_empty = 1'b0;
    end while (!bus.fifo_wr_en && n < 100);
    chk({tag, "_wr_en_latency"}, 32'(n), 32'(lat_exp));
    chk({tag, "_busy_latency"}, 32'(first_busy), 32'(busy_exp));

    while (bus.fifo_wr_en && wc < 600) begin
      chk({tag, "_data"}, 32'(bus.fifo_wr_data), 32'(wc % 256));
      bus.almost_full = (wc >= k);
      wc++;
      @(negedge sys_clk);
    end
    chk({tag, "_words"}, 32'(wc), 32'(k + 1));
    chk({tag, "_busy_in_done"}, 32'(bus.wr_busy), 32'd1);
    chk({tag, "_done_early"}, 32'(bus.burst_done), 32'd0);
    bus.almost_full = 1'b0;

    @(negedge sys_clk);
    chk({tag, "_done_pulse"}, 32'(bus.burst_done), 32'd1);
    chk({tag, "_len"}, 32'(bus.burst_len), 32'(k + 1));
    chk({tag, "_busy_after"}, 32'(bus.wr_busy), 32'd0);
    chk({tag, "_wr_en_after"}, 32'(bus.fifo_wr_en), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    vectors          = 0;
    miscompares      = 0;
    sys_rst_n        = 1'b0;
    bus.almost_empty = 1'b0;
    bus.almost_full  = 1'b0;

    // Held in reset for 50 cycles
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      chk_reset_outputs("reset_hold");
    end
    sys_rst_n = 1'b1;

    // Idle with almost_empty low
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk_reset_outputs("idle");
    end

    // Full 256-word burst; almost_empty drops during the settle delay
    bus.almost_empty = 1'b1;
    do_burst(255, 14, 3, 1'b1, "full");
    for (int i = 0; i < 20; i++) @(negedge sys_clk);
    chk("idle_after_full_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("idle_after_full_busy", 32'(bus.wr_busy), 32'd0);
    chk("idle_after_full_len", 32'(bus.burst_len), 32'd256);

    // almost_full already high on the first write: single word
    bus.almost_empty = 1'b1;
    do_burst(0, 14, 3, 1'b0, "single");

    // almost_empty held high: immediate re-arm, IDLE + fresh delay
    for (int b = 0; b < 4; b++) begin
      k = int'($urandom_range(300, 0));
      do_burst(k, 12, 1, 1'b0, $sformatf("rearm%0d", b));
    end

    // Asynchronous reset pulse mid-burst at data 0x37
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!bus.fifo_wr_en && n < 100);
    while (bus.fifo_wr_data != 8'h37 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("pre_reset_data", 32'(bus.fifo_wr_data), 32'h37);
    chk("pre_reset_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    #1 sys_rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    sys_rst_n = 1'b1;

    // Restart after reset: full synchroniser latency, data from 0
    k = int'($urandom_range(80, 1));
    do_burst(k, 14, 3, 1'b1, "post_reset");
    for (int i = 0; i < 20; i++) @(negedge sys_clk);
    chk("final_idle_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("final_idle_busy", 32'(bus.wr_busy), 32'd0);
    chk("final_idle_done", 32'(bus.burst_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
